// File: rtl/integral_image_builder.sv
// Streaming integral-image generator for one 160x120 frame of 4-bit pixels.
// Two-stage pipeline: row accumulation, then add the previous row's integral from a line buffer.
module integral_image_builder #(
    parameter int II_WIDTH    = 160,
    parameter int II_HEIGHT   = 120,
    parameter int PIXEL_WIDTH = 4,
    parameter int DATA_WIDTH  = 21,
    parameter int ADDR_WIDTH  = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   pixel_valid,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   frame_done,
    output logic                   frame_ready
);

    localparam int XW     = $clog2(II_WIDTH);
    localparam int YW     = $clog2(II_HEIGHT);
    localparam int STAGES = 2;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                 state, state_nxt;
    logic [XW-1:0]          x, cur_x, s1_x;
    logic [YW-1:0]          y, cur_y, s1_y;
    logic [ADDR_WIDTH-1:0]  addr, cur_addr, s1_addr;
    logic [DATA_WIDTH-1:0]  rowsum, lb_rd, ii_val;
    logic [STAGES:1]        vld_pipe;
    logic                   s1_last;
    logic                   accept, x_last, y_last, px_last, commit;

    logic [DATA_WIDTH-1:0]  lb [II_WIDTH];

    // frame_start forces the current coordinate to (0,0) so a same-cycle pixel opens the new frame
    always_comb begin
        accept   = pixel_valid & (frame_start | (state == FILL));
        cur_x    = frame_start ? '0 : x;
        cur_y    = frame_start ? '0 : y;
        cur_addr = frame_start ? '0 : addr;
        x_last   = (cur_x == XW'(II_WIDTH - 1));
        y_last   = (cur_y == YW'(II_HEIGHT - 1));
        px_last  = x_last & y_last;
    end

    always_comb begin
        state_nxt = state;
        if (frame_start)
            state_nxt = FILL;
        if (accept && px_last)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Stage 1: coordinate counters and row accumulation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x           <= '0;
            y           <= '0;
            addr        <= '0;
            rowsum      <= '0;
            s1_x        <= '0;
            s1_y        <= '0;
            s1_addr     <= '0;
            s1_last     <= 1'b0;
            vld_pipe[1] <= 1'b0;
        end else begin
            vld_pipe[1] <= accept;
            if (accept) begin
                x       <= x_last ? '0 : cur_x + 1'b1;
                y       <= x_last ? (y_last ? '0 : cur_y + 1'b1) : cur_y;
                addr    <= px_last ? '0 : cur_addr + 1'b1;
                rowsum  <= (cur_x == '0 ? '0 : rowsum) + DATA_WIDTH'(pixel_in);
                s1_x    <= cur_x;
                s1_y    <= cur_y;
                s1_addr <= cur_addr;
                s1_last <= px_last;
            end else if (frame_start) begin
                x      <= '0;
                y      <= '0;
                addr   <= '0;
                rowsum <= '0;
            end
        end
    end

    // Row 0 has no previous row, so the stale buffer contents are masked instead of cleared
    assign lb_rd  = lb[s1_x];
    assign ii_val = rowsum + ((s1_y == '0) ? '0 : lb_rd);
    // A stage-1 pixel of an aborted frame must not reach the buffer
    assign commit = vld_pipe[1] & ~frame_start;

    always_ff @(posedge clk) begin
        if (commit)
            lb[s1_x] <= ii_val;
    end

    // Stage 2: registered buffer write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe[2] <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            frame_ready <= 1'b0;
        end else begin
            vld_pipe[2] <= commit;
            frame_done  <= commit & s1_last;
            if (commit) begin
                wr_addr <= s1_addr;
                wr_data <= ii_val;
            end
            if (frame_start)
                frame_ready <= 1'b0;
            else if (commit && s1_last)
                frame_ready <= 1'b1;
        end
    end

    assign wr_en = vld_pipe[STAGES];

endmodule

// File: tb/tb_integral_image_builder.sv
// Scoreboard bench for integral_image_builder: a column-sum model queues expected writes,
// a negedge monitor pops and compares them; scenario tasks add closed-form spot checks.
module tb_integral_image_builder;

    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        pixel_valid;
    logic [3:0]  pixel_in;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [20:0] wr_data;
    logic        frame_done;
    logic        frame_ready;

    integral_image_builder dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pixel_valid (pixel_valid),
        .pixel_in    (pixel_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_done  (frame_done),
        .frame_ready (frame_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        bit last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_wr = 0;
    int   n_done = 0;
    int   first_wr_cyc = -1;
    int   first_addr = -1;
    int   first_data = -1;
    bit   bit20_seen = 0;
    int   wmem [N];

    // reference model state: per-column running sums, accumulated across the row
    int   colsum [W];
    int   mx, my, acc;
    bit   m_fill = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (wr_en === 1'b1) begin
            n_wr++;
            if (first_wr_cyc < 0) begin
                first_wr_cyc = cyc;
                first_addr   = int'(wr_addr);
                first_data   = int'(wr_data);
            end
            if (wr_data[20] === 1'b1) bit20_seen = 1;
            if (wr_addr < 15'(N)) wmem[wr_addr] = int'(wr_data);
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%0d", wr_addr, wr_data);
            end else begin
                e = sb.pop_front();
                if (wr_addr !== 15'(e.addr) || wr_data !== 21'(e.data) ||
                    frame_done !== e.last || frame_ready !== e.last) begin
                    failures++;
                    $display("FAIL write got addr=%0d data=%0d done=%b ready=%b want addr=%0d data=%0d done=%b ready=%b",
                             wr_addr, wr_data, frame_done, frame_ready, e.addr, e.data, e.last, e.last);
                end
            end
        end else if (frame_done === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_without_write frame_done=1 wr_en=%b", wr_en);
        end
        if (frame_done === 1'b1) n_done++;
    end

    task automatic step(input logic fs, input logic pv, input logic [3:0] pix);
        frame_start = fs;
        pixel_valid = pv;
        pixel_in    = pix;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        if (fs) begin
            sb.delete();
            mx = 0;
            my = 0;
            acc = 0;
            m_fill = 1;
            foreach (colsum[i]) colsum[i] = 0;
        end
        if (pv && m_fill) begin
            colsum[mx] += int'(pix);
            if (mx == 0) acc = 0;
            acc += colsum[mx];
            sb.push_back('{my * W + mx, acc, (mx == W - 1) && (my == H - 1)});
            if (mx == W - 1) begin
                mx = 0;
                if (my == H - 1) begin
                    my = 0;
                    m_fill = 0;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end
    endtask

    task automatic clear_wmem();
        foreach (wmem[i]) wmem[i] = -1;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        pixel_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 15'd0 || wr_data !== 21'd0 ||
            frame_done !== 1'b0 || frame_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got en=%b addr=%0d data=%0d done=%b ready=%b want all 0",
                     wr_en, wr_addr, wr_data, frame_done, frame_ready);
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_idle_ignored();
        int w0 = n_wr;
        repeat (5) step(1'b0, 1'b1, 4'd5);
        repeat (3) step(1'b0, 1'b0, 4'd0);
        check_int("idle_no_writes", n_wr - w0, 0);
        checks++;
        if (dut.x !== '0 || dut.y !== '0) begin
            failures++;
            $display("FAIL idle_counters got x=%0d y=%0d want x=0 y=0", dut.x, dut.y);
        end
    endtask

    task automatic test_all_ones();
        int w0 = n_wr;
        int d0 = n_done;
        clear_wmem();
        step(1'b1, 1'b1, 4'd1);
        for (int i = 1; i < N; i++) step(1'b0, 1'b1, 4'd1);
        repeat (3) step(1'b0, 1'b0, 4'd0);
        check_int("ones_addr0", wmem[0], 1);
        check_int("ones_addr159", wmem[159], 160);
        check_int("ones_addr_x9_y5", wmem[5 * W + 9], 60);
        check_int("ones_addr19199", wmem[N - 1], 19200);
        check_int("ones_write_count", n_wr - w0, N);
        check_int("ones_done_pulses", n_done - d0, 1);
        check_int("ones_frame_ready", int'(frame_ready), 1);
        check_int("ones_sb_drained", sb.size(), 0);
    endtask

    task automatic test_all_fifteens();
        clear_wmem();
        bit20_seen = 0;
        step(1'b1, 1'b1, 4'd15);
        for (int i = 1; i < N; i++) step(1'b0, 1'b1, 4'd15);
        repeat (3) step(1'b0, 1'b0, 4'd0);
        check_int("f15_addr0", wmem[0], 15);
        check_int("f15_addr19199", wmem[N - 1], 288000);
        check_int("f15_bit20_set", int'(bit20_seen), 0);
        check_int("f15_sb_drained", sb.size(), 0);
    endtask

    // gapped valid for the first rows exercises stalls; remainder runs back-to-back
    task automatic test_ramp_gaps();
        int w0 = n_wr;
        int pres = -1;
        step(1'b1, 1'b0, 4'd0);
        first_wr_cyc = -1;
        for (int i = 0; i < N; i++) begin
            if (i == 0) pres = cyc;
            step(1'b0, 1'b1, 4'((i % W) % 16));
            if (i < 8 * W) step(1'b0, 1'b0, 4'd0);
        end
        repeat (3) step(1'b0, 1'b0, 4'd0);
        check_int("ramp_write_count", n_wr - w0, N);
        check_int("ramp_first_latency", first_wr_cyc - pres, 2);
        check_int("ramp_sb_drained", sb.size(), 0);
    endtask

    task automatic test_restart();
        clear_wmem();
        step(1'b1, 1'b1, 4'd3);
        check_int("restart_ready_cleared", int'(frame_ready), 0);
        for (int i = 1; i < 5000; i++) step(1'b0, 1'b1, 4'd3);
        step(1'b1, 1'b1, 4'd2);
        first_wr_cyc = -1;
        check_int("restart_ready_low", int'(frame_ready), 0);
        for (int i = 1; i < N; i++) step(1'b0, 1'b1, 4'd2);
        repeat (3) step(1'b0, 1'b0, 4'd0);
        check_int("restart_first_addr", first_addr, 0);
        check_int("restart_first_data", first_data, 2);
        check_int("restart_addr19199", wmem[N - 1], 38400);
        check_int("restart_sb_drained", sb.size(), 0);
    endtask

    task automatic test_reset_mid_frame();
        int w0;
        step(1'b1, 1'b1, 4'd1);
        for (int i = 1; i < 300; i++) step(1'b0, 1'b1, 4'd1);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 15'd0 || wr_data !== 21'd0 ||
            frame_done !== 1'b0 || frame_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got en=%b addr=%0d data=%0d done=%b ready=%b want all 0",
                     wr_en, wr_addr, wr_data, frame_done, frame_ready);
        end
        sb.delete();
        m_fill = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        w0 = n_wr;
        repeat (10) step(1'b0, 1'b1, 4'd1);
        repeat (3) step(1'b0, 1'b0, 4'd0);
        check_int("midreset_no_writes", n_wr - w0, 0);
        checks++;
        if (dut.x !== '0 || dut.y !== '0) begin
            failures++;
            $display("FAIL midreset_counters got x=%0d y=%0d want x=0 y=0", dut.x, dut.y);
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignored();
        test_all_ones();
        test_all_fifteens();
        test_ramp_gaps();
        test_restart();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/integral_image_builder.md
# integral_image_builder

Upstream stage of the Haar classifiers. Consumes a raster-order stream of 4-bit grayscale pixels for one 160x120 frame, computes the integral image on the fly, and writes each 21-bit integral value into the integral image buffer at address y*160+x. When the whole frame is written it signals the detection state machine, which then drives the classifiers' reads from the buffer.

## Interface
- II_WIDTH, 160, pixels per row
- II_HEIGHT, 120, rows per frame
- PIXEL_WIDTH, 4, grayscale bits per pixel
- DATA_WIDTH, 21, integral value width (signed, always non-negative here)
- ADDR_WIDTH, 15, buffer address width

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset: asynchronous assert, active-low (0 = reset)
- frame_start  in  1  one-cycle pulse: start or restart a frame
- pixel_valid  in  1  pixel_in valid this cycle
- pixel_in  in  PIXEL_WIDTH  unsigned pixel, raster order (left to right, top to bottom)
- wr_en  out  1  buffer write strobe, one cycle per pixel
- wr_addr  out  ADDR_WIDTH  buffer write address y*II_WIDTH+x
- wr_data  out  DATA_WIDTH  integral value II(x,y)
- frame_done  out  1  one-cycle pulse coincident with the final write of a frame
- frame_ready  out  1  level: buffer holds a complete frame

## Operation
- II(x,y) = sum of pixels p(i,j) for i<=x, j<=y; computed as rowsum(x,y) + II(x,y-1).
- rowsum accumulator reset at x==0; line buffer of II_WIDTH x DATA_WIDTH holds the previous row's II; its output is forced to 0 when y==0, so it needs no clearing.
- States: IDLE -> FILL on frame_start; FILL -> IDLE when pixel (159,119) is accepted; frame_start in any state (including FILL) restarts at (0,0).
- In IDLE, pixel_valid is ignored: no counter change, no write.
- In FILL, each pixel_valid cycle accepts one pixel; x increments and wraps 159->0 with y++. Gaps in pixel_valid are allowed; no backpressure exists.
- frame_start clears frame_ready, x, y, rowsum, and pipeline valid bits. No write belonging to the aborted frame issues after the frame_start edge.
- frame_start and pixel_valid in the same cycle: that pixel is (0,0) of the new frame.
- Arithmetic: unsigned pixel, zero-extended to DATA_WIDTH. Maximum value is 160*120*15 = 288000, below 2^20, so there is no overflow and the sign bit is always 0. Maximum address is 19199.
- frame_done and frame_ready assert together with the write of (159,119). frame_ready stays high until the next frame_start or reset.

## Timing
- Two-stage pipeline with registered outputs. For a pixel sampled at edge k:
  - stage 1 at edge k updates rowsum and latches x, y and address;
  - stage 2 at edge k+1 adds the line buffer value and writes wr_* and the line buffer entry x.
  - wr_en is high during the cycle after edge k+1; latency is 2 clocks.
- Full throughput: one pixel per clock sustained, with back-to-back writes.
- Line buffer read of entry x occurs before the same-edge write of entry x, so the read returns the previous row's value.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_ready=0, state IDLE, x=y=0, pipeline empty.
- Reset asserted mid-frame clears everything immediately (asynchronously). No write occurs until a new frame_start after release.
- wr_addr and wr_data are don't-care when wr_en=0, but they hold their last value.

## Test plan
- All pixels = 1, continuous valid:
  - wr_data = (x+1)(y+1) at every address;
  - addr 159 carries 160, addr 19199 carries 19200;
  - frame_done pulses once, with the last write;
  - frame_ready is 1 afterwards.
- All pixels = 15: addr 0 = 15, addr 19199 = 288000, bit 20 never set.
- Ramp pixel = x mod 16 with pixel_valid toggling 1010...:
  - writes match a reference model;
  - exactly 19200 wr_en pulses;
  - first write 2 cycles after the first accepted pixel.
- frame_start after 5000 pixels, then a full frame of 2s:
  - frame_ready drops to 0;
  - the next write is addr 0 with data 2;
  - no stale addresses after the restart edge;
  - addr 19199 = 38400.
- pixel_valid pulses while IDLE before any frame_start: no wr_en, and the counters stay at 0.
- rst low mid-frame: all outputs 0 in the same cycle; after release, pixel_valid is ignored until frame_start.
